spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync.sv | 32 +++
 rtl/spi_slave_rx.sv | 155 +++++++++++++++
 tb/tb_spi_slave_rx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared defaults and FSM state encoding for the SPI slave receiver.
package spi_pkg;

  localparam int unsigned DATA_W_DEFAULT      = 12;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StWaitCs
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for one asynchronous pin, with rise/fall detection
// against one extra delay register.
module spi_sync #(
  parameter int unsigned STAGES   = 2,
  parameter logic        IDLE_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{IDLE_VAL}};
      r_dly  <= IDLE_VAL;
    end else begin
      r_sync <= STAGES'({r_sync, i_d});
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = o_q & ~r_dly;
  assign o_fall = ~o_q & r_dly;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive-only slave: synchronizes the pins, assembles DATA_W-bit
// words MSB first and hands them out over a valid/ready port.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned       CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);

  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_mosi_s;
  logic w_unused_sclk;

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  spi_state_e             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [DATA_W-1:0]      r_shift;
  logic                   r_done;
  logic [DATA_W-1:0]      r_dout;
  logic                   r_dout_valid;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   r_busy;

  spi_sync #(
    .STAGES   (SYNC_STAGES),
    .IDLE_VAL (1'b1)
  ) u_cs_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (cs),
    .o_q     (w_cs_q),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  spi_sync #(
    .STAGES   (SYNC_STAGES),
    .IDLE_VAL (1'b0)
  ) u_sclk_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (sclk),
    .o_q     (w_sclk_q),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  // Mode 0 only needs the sclk rising edge.
  assign w_unused_sclk = w_sclk_q ^ w_sclk_fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= SYNC_STAGES'({r_mosi_sync, mosi});
    end
  end

  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_done       <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (w_cs_fall) begin
            r_state <= StShift;
            r_cnt   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b1;
          end
        end
        StShift: begin
          if (w_cs_q) begin
            // Chip select released before a full word: drop it.
            r_frame_err <= 1'b1;
            r_state     <= StIdle;
            r_busy      <= 1'b0;
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[DATA_W-2:0], w_mosi_s};
            if (r_cnt != CNT_FULL) begin
              r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt == CNT_LAST) begin
              r_state <= StWaitCs;
              r_done  <= 1'b1;
            end
          end
        end
        StWaitCs: begin
          if (w_sclk_rise) begin
            r_frame_err <= 1'b1;
          end
          if (w_cs_rise) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase

      // A word completing while the held word is still unconsumed is lost.
      if (r_done) begin
        if (r_dout_valid && !dout_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_dout       <= r_shift;
          r_dout_valid <= 1'b1;
        end
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = r_busy;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a frame-level model predicts delivery and
// error events from the driven SPI traffic and is compared every cycle.
module tb_spi_slave_rx;

  localparam int unsigned DW      = 12;
  localparam int unsigned SS      = 2;
  localparam int          LAT_DLV = SS + 2;
  localparam int          LAT_ERR = SS + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cs;
  logic          sclk;
  logic          mosi;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  spi_slave_rx #(
    .DATA_W      (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .sclk       (sclk),
    .mosi       (mosi),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] w;
  } dlv_t;

  dlv_t          dq[$];
  int            eq[$];
  int            cyc = 0;
  logic [DW-1:0] m_dout  = '0;
  logic          m_valid = 1'b0;
  logic          m_ferr  = 1'b0;
  logic          m_ovr   = 1'b0;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] seen_word = '0;
  int            seen_vcyc = 0;
  int            seen_vlow = 0;
  int            seen_ferr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: advance on each clock edge using the same sampled inputs as the DUT.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        dq.delete();
        eq.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
      end else begin
        m_ferr = 1'b0;
        if (eq.size() > 0 && eq[0] == cyc) begin
          m_ferr = 1'b1;
          void'(eq.pop_front());
        end
        if (dq.size() > 0 && dq[0].due == cyc) begin
          if (m_valid && !dout_ready) begin
            m_ovr = 1'b1;
          end else begin
            m_dout  = dq[0].w;
            m_valid = 1'b1;
          end
          void'(dq.pop_front());
        end else if (m_valid && dout_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("dout_valid", {31'd0, dout_valid}, {31'd0, m_valid});
        chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        if (m_valid) chk("dout", 32'(dout), 32'(m_dout));
        if (dout_valid) begin
          seen_word = dout;
          seen_vcyc++;
        end else begin
          seen_vlow++;
        end
        if (frame_err) seen_ferr++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One SPI frame of nbits clocks, sclk = clk/10; bits past DW send ones.
  task automatic frame(input logic [DW-1:0] w, input int nbits, input bit raise,
                       input bit pulse_rdy);
    int   k;
    dlv_t d;
    tick(1);
    cs = 1'b0;
    tick(5);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < DW) ? w[DW-1-i] : 1'b1;
      tick(5);
      sclk = 1'b1;
      k    = cyc;
      if (i == DW - 1) begin
        d.due = k + LAT_DLV;
        d.w   = w;
        dq.push_back(d);
      end
      if (i >= DW) eq.push_back(k + LAT_ERR);
      for (int j = 0; j < 5; j++) begin
        tick(1);
        if (pulse_rdy && i == DW - 1) begin
          if (cyc == k + LAT_DLV - 1) dout_ready = 1'b1;
          else if (cyc == k + LAT_DLV) dout_ready = 1'b0;
        end
      end
      sclk = 1'b0;
    end
    tick(5);
    if (raise) begin
      cs = 1'b1;
      if (nbits < DW) eq.push_back(cyc + LAT_ERR);
      tick(8);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int f0, v0, l0;
    rst_n      = 1'b0;
    cs         = 1'b1;
    sclk       = 1'b0;
    mosi       = 1'b0;
    dout_ready = 1'b1;
    tick(3);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick(4);

    // Basic frame with consumer always ready.
    f0 = seen_ferr; v0 = seen_vcyc;
    frame(12'hABC, 12, 1'b1, 1'b0);
    chk("abc_word", 32'(seen_word), 32'hABC);
    chk("abc_valid_cycles", 32'(seen_vcyc - v0), 32'd1);
    chk("abc_ferr", 32'(seen_ferr - f0), 32'd0);

    // Aborted after 5 bits, then a clean frame.
    f0 = seen_ferr; v0 = seen_vcyc;
    frame(12'hABC, 5, 1'b1, 1'b0);
    chk("abort_ferr", 32'(seen_ferr - f0), 32'd1);
    chk("abort_no_valid", 32'(seen_vcyc - v0), 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    frame(12'h555, 12, 1'b1, 1'b0);
    chk("x555_word", 32'(seen_word), 32'h555);

    // Two extra sclk edges after the word completes.
    f0 = seen_ferr;
    frame(12'hFFF, 14, 1'b1, 1'b0);
    chk("fff_word", 32'(seen_word), 32'hFFF);
    chk("fff_ferr", 32'(seen_ferr - f0), 32'd2);

    // Consumer stalled: second word is dropped.
    dout_ready = 1'b0;
    frame(12'hABC, 12, 1'b1, 1'b0);
    frame(12'h123, 12, 1'b1, 1'b0);
    chk("ovr_dout", 32'(dout), 32'hABC);
    chk("ovr_seen", 32'(seen_word), 32'hABC);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_valid_held", {31'd0, dout_valid}, 32'd1);
    dout_ready = 1'b1;
    tick(2);
    chk("ovr_valid_clr", {31'd0, dout_valid}, 32'd0);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Reset in the middle of a frame.
    frame(12'hABC, 6, 1'b0, 1'b0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    f0    = seen_ferr;
    rst_n = 1'b0;
    cs    = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(6);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_overrun", {31'd0, overrun}, 32'd0);
    v0 = seen_vcyc;
    frame(12'h123, 12, 1'b1, 1'b0);
    chk("rstmid_word", 32'(seen_word), 32'h123);
    chk("rstmid_one_dlv", 32'(seen_vcyc - v0), 32'd1);
    chk("rstmid_ferr", 32'(seen_ferr - f0), 32'd0);

    // Delivery coinciding with a handshake on a held word.
    dout_ready = 1'b0;
    frame(12'h456, 12, 1'b1, 1'b0);
    chk("hs_first", 32'(dout), 32'h456);
    l0 = seen_vlow;
    frame(12'h789, 12, 1'b1, 1'b1);
    chk("hs_word", 32'(dout), 32'h789);
    chk("hs_valid", {31'd0, dout_valid}, 32'd1);
    chk("hs_continuous", 32'(seen_vlow - l0), 32'd0);
    chk("hs_no_overrun", {31'd0, overrun}, 32'd0);
    dout_ready = 1'b1;
    tick(3);
    chk("hs_drained", {31'd0, dout_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
